// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// master drives bytes, slave (the loader) returns in_ready.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Parses SYNC, 16-bit word count, 4*N big-endian data bytes and an XOR
// checksum; writes each word to consecutive addresses from 0 and releases
// the processor reset only after a complete image with a good checksum.
//
// state   | meaning
// S_SYNC  | hunting for the frame start marker, other bytes dropped
// S_CNT_HI| waiting for the high byte of the word count
// S_CNT_LO| waiting for the low byte; size is validated here
// S_WORD  | collecting data bytes, four per instruction word
// S_CHECK | waiting for the checksum byte
// S_DONE  | image good, processor released (terminal)
// S_ERR   | bad size or checksum, processor held (terminal)
module imem_loader #(
  parameter int         ADDR_W    = 5,
  parameter int         MAX_WORDS = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      src,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_SYNC, S_CNT_HI, S_CNT_LO, S_WORD, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic        last_word;
  logic [7:0]  cnt_hi;
  logic [15:0] n_words;
  logic [15:0] n_new;
  logic [1:0]  byte_idx;
  logic [7:0]  xor_acc;

  // Ready is a pure state decode so it never loops back through in_valid.
  assign src.in_ready = (state != S_DONE) && (state != S_ERR);
  assign accept       = src.in_valid & src.in_ready;
  assign n_new        = {cnt_hi, src.in_data};
  assign last_word    = (16'(words_loaded) + 16'd1) == n_words;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_SYNC;
    else       state <= state_next;
  end

  // Next-state decode; only accepted bytes move the machine.
  always_comb begin
    state_next = state;
    case (state)
      S_SYNC:   if (accept && src.in_data == SYNC_BYTE) state_next = S_CNT_HI;
      S_CNT_HI: if (accept) state_next = S_CNT_LO;
      S_CNT_LO: begin
        if (accept) begin
          if (n_new > 16'(MAX_WORDS)) state_next = S_ERR;
          else if (n_new == 16'd0)    state_next = S_CHECK;
          else                        state_next = S_WORD;
        end
      end
      S_WORD:   if (accept && byte_idx == 2'd3 && last_word) state_next = S_CHECK;
      S_CHECK: begin
        if (accept) state_next = (src.in_data == xor_acc) ? S_DONE : S_ERR;
      end
      S_DONE:   state_next = S_DONE;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_SYNC;
    endcase
  end

  // Datapath: count capture, word assembly, write strobe and status flags.
  // wr_data doubles as the shift register; the memory samples it during the
  // wr_en cycle, before the next accepted byte can shift it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      cnt_hi       <= '0;
      n_words      <= '0;
      byte_idx     <= '0;
      xor_acc      <= '0;
    end else begin
      wr_en     <= 1'b0;
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERR);
      cpu_reset <= (state_next != S_DONE);
      if (accept) begin
        case (state)
          S_SYNC: if (src.in_data == SYNC_BYTE) xor_acc <= '0;
          S_CNT_HI: begin
            cnt_hi  <= src.in_data;
            xor_acc <= xor_acc ^ src.in_data;
          end
          S_CNT_LO: begin
            n_words  <= n_new;
            xor_acc  <= xor_acc ^ src.in_data;
            byte_idx <= '0;
          end
          S_WORD: begin
            xor_acc  <= xor_acc ^ src.in_data;
            wr_data  <= {wr_data[23:0], src.in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_en        <= 1'b1;
              wr_addr      <= words_loaded[ADDR_W-1:0];
              words_loaded <= words_loaded + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan
// plus randomized frames, checked against a frame-parsing reference model.
module tb_imem_loader;
  localparam int ADDR_W    = 5;
  localparam int MAX_WORDS = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if bus();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_reset, done, error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .src(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed writes, captured mid-cycle
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          obs_wl[$];
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(wr_data);
      obs_cyc.push_back(cyc);
      obs_wl.push_back(int'(words_loaded));
    end
  end

  // driver observations
  int   acc_cyc[$];
  logic term_done, term_err, term_cpu;

  // reference model results
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_wstream[$];
  logic        exp_done, exp_err, exp_term;
  int          exp_loaded, exp_consumed;

  // Parse a byte stream the way the frame format defines it.
  task automatic model(input logic [7:0] s[$]);
    int p, n, c;
    logic [7:0] x;
    exp_addr.delete(); exp_data.delete(); exp_wstream.delete();
    exp_done = 0; exp_err = 0; exp_term = 0; exp_loaded = 0;
    exp_consumed = s.size();
    p = 0;
    while (p < s.size() && s[p] != 8'hA5) p++;
    if (p + 2 >= s.size()) return;
    n = int'({s[p+1], s[p+2]});
    x = s[p+1] ^ s[p+2];
    if (n > MAX_WORDS) begin
      exp_err = 1; exp_term = 1; exp_consumed = p + 3;
      return;
    end
    for (int k = 0; k < n; k++) begin
      int b = p + 3 + 4 * k;
      if (b + 3 >= s.size()) return;
      exp_data.push_back({s[b], s[b+1], s[b+2], s[b+3]});
      exp_addr.push_back(k);
      exp_wstream.push_back(b + 3);
      x = x ^ s[b] ^ s[b+1] ^ s[b+2] ^ s[b+3];
      exp_loaded = k + 1;
    end
    c = p + 3 + 4 * n;
    if (c >= s.size()) return;
    exp_term = 1;
    exp_consumed = c + 1;
    if (s[c] == x) exp_done = 1;
    else           exp_err  = 1;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); obs_wl.delete();
    acc_cyc.delete();
    term_done = 'x; term_err = 'x; term_cpu = 'x;
  endtask

  task automatic pulse_reset();
    bus.in_valid = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    clear_obs();
  endtask

  // Offer each byte; a byte not taken within 4 cycles is abandoned.
  task automatic send_stream(input logic [7:0] s[$], input int gap_min, input int gap_max);
    for (int i = 0; i < s.size(); i++) begin
      int w = 0;
      bus.in_valid = 1;
      bus.in_data  = s[i];
      while (bus.in_ready !== 1'b1 && w < 4) begin
        @(negedge clk);
        w++;
      end
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        acc_cyc.push_back(cyc);
        if (i == exp_consumed - 1 && exp_term) begin
          term_done = done; term_err = error; term_cpu = cpu_reset;
        end
      end
      bus.in_valid = 0;
      if (gap_max > 0) repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
    end
    bus.in_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] s[$];
    bus.in_valid = 1; bus.in_data = 8'hA5;
    reset = 1;
    @(negedge clk); @(negedge clk);
    reset = 0; bus.in_valid = 0;
    clear_obs();
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_reset: got %b expected 1", cpu_reset); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b expected 0", error); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
    n_cmp++; if (wr_addr !== '0) begin n_bad++; $display("FAIL rst_wr_addr: got %0d expected 0", wr_addr); end
    n_cmp++; if (wr_data !== 32'h0) begin n_bad++; $display("FAIL rst_wr_data: got %h expected 0", wr_data); end
    n_cmp++; if (words_loaded !== '0) begin n_bad++; $display("FAIL rst_words_loaded: got %0d expected 0", words_loaded); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    // a sync byte presented during reset must not be taken: these bytes stay noise
    s = {8'h00, 8'h00, 8'h00};
    model(s);
    send_stream(s, 0, 0);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_wins_done: got %b expected 0", done); end
    n_cmp++; if (obs_data.size() != 0) begin n_bad++; $display("FAIL rst_wins_writes: got %0d expected 0", obs_data.size()); end
  endtask

  task automatic test_normal();
    logic [7:0]  s[$];
    logic [31:0] ed[2];
    ed[0] = 32'h20080005; ed[1] = 32'h20090003;
    s = {8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03, 8'h05};
    pulse_reset();
    model(s);
    send_stream(s, 0, 0);
    n_cmp++; if (obs_data.size() != 2) begin n_bad++; $display("FAIL normal_nwrites: got %0d expected 2", obs_data.size()); end
    for (int k = 0; k < 2; k++) begin
      if (k < obs_data.size()) begin
        n_cmp++; if (obs_data[k] !== ed[k]) begin n_bad++; $display("FAIL normal_data%0d: got %h expected %h", k, obs_data[k], ed[k]); end
        n_cmp++; if (obs_addr[k] != k) begin n_bad++; $display("FAIL normal_addr%0d: got %0d expected %0d", k, obs_addr[k], k); end
        n_cmp++; if (obs_wl[k] != k + 1) begin n_bad++; $display("FAIL normal_wl%0d: got %0d expected %0d", k, obs_wl[k], k + 1); end
        n_cmp++; if (obs_cyc[k] != acc_cyc[3 + 4 * k + 3]) begin n_bad++; $display("FAIL normal_wcyc%0d: got %0d expected %0d", k, obs_cyc[k], acc_cyc[3 + 4 * k + 3]); end
      end
    end
    n_cmp++; if (term_done !== 1'b1) begin n_bad++; $display("FAIL normal_done_edge: got %b expected 1", term_done); end
    n_cmp++; if (term_cpu !== 1'b0) begin n_bad++; $display("FAIL normal_cpu_edge: got %b expected 0", term_cpu); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL normal_error: got %b expected 0", error); end
    n_cmp++; if (words_loaded !== 6'd2) begin n_bad++; $display("FAIL normal_words_loaded: got %0d expected 2", words_loaded); end
    n_cmp++; if (wr_addr !== 5'd1) begin n_bad++; $display("FAIL normal_wr_addr_hold: got %0d expected 1", wr_addr); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL normal_in_ready: got %b expected 0", bus.in_ready); end
  endtask

  task automatic test_noise_gaps();
    logic [7:0] s[$];
    s = {8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
         8'h20, 8'h09, 8'h00, 8'h03, 8'h05};
    pulse_reset();
    model(s);
    send_stream(s, 3, 3);
    n_cmp++; if (obs_data.size() != 2) begin n_bad++; $display("FAIL noise_nwrites: got %0d expected 2", obs_data.size()); end
    if (obs_data.size() == 2) begin
      n_cmp++; if (obs_data[0] !== 32'h20080005) begin n_bad++; $display("FAIL noise_data0: got %h expected 20080005", obs_data[0]); end
      n_cmp++; if (obs_data[1] !== 32'h20090003) begin n_bad++; $display("FAIL noise_data1: got %h expected 20090003", obs_data[1]); end
    end
    n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL noise_status: got done=%b error=%b expected done=1 error=0", done, error); end
    n_cmp++; if (acc_cyc.size() != 15) begin n_bad++; $display("FAIL noise_accepted: got %0d expected 15", acc_cyc.size()); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s[$];
    s = {8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03, 8'h04, 8'h77};
    pulse_reset();
    model(s);
    send_stream(s, 0, 0);
    n_cmp++; if (obs_data.size() != 2) begin n_bad++; $display("FAIL badcs_nwrites: got %0d expected 2", obs_data.size()); end
    n_cmp++; if (term_err !== 1'b1) begin n_bad++; $display("FAIL badcs_error_edge: got %b expected 1", term_err); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL badcs_done: got %b expected 0", done); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL badcs_cpu_reset: got %b expected 1", cpu_reset); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL badcs_in_ready: got %b expected 0", bus.in_ready); end
    n_cmp++; if (acc_cyc.size() != 12) begin n_bad++; $display("FAIL badcs_accepted: got %0d expected 12", acc_cyc.size()); end
  endtask

  task automatic test_oversize();
    logic [7:0] s[$];
    s = {8'hA5, 8'h00, 8'h21, 8'h11, 8'h22};
    pulse_reset();
    model(s);
    send_stream(s, 0, 0);
    n_cmp++; if (term_err !== 1'b1) begin n_bad++; $display("FAIL oversize_error_edge: got %b expected 1", term_err); end
    n_cmp++; if (term_done !== 1'b0) begin n_bad++; $display("FAIL oversize_done_edge: got %b expected 0", term_done); end
    n_cmp++; if (obs_data.size() != 0) begin n_bad++; $display("FAIL oversize_writes: got %0d expected 0", obs_data.size()); end
    n_cmp++; if (acc_cyc.size() != 3) begin n_bad++; $display("FAIL oversize_accepted: got %0d expected 3", acc_cyc.size()); end
  endtask

  task automatic test_empty();
    logic [7:0] s[$];
    s = {8'hA5, 8'h00, 8'h00, 8'h00};
    pulse_reset();
    model(s);
    send_stream(s, 0, 0);
    n_cmp++; if (obs_data.size() != 0) begin n_bad++; $display("FAIL empty_writes: got %0d expected 0", obs_data.size()); end
    n_cmp++; if (term_done !== 1'b1) begin n_bad++; $display("FAIL empty_done_edge: got %b expected 1", term_done); end
    n_cmp++; if (cpu_reset !== 1'b0) begin n_bad++; $display("FAIL empty_cpu_reset: got %b expected 0", cpu_reset); end
    n_cmp++; if (words_loaded !== '0) begin n_bad++; $display("FAIL empty_words_loaded: got %0d expected 0", words_loaded); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[$];
    logic [7:0] part[$];
    s = {8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03, 8'h05};
    part = s[0:5];
    pulse_reset();
    model(part);
    send_stream(part, 0, 0);
    pulse_reset();
    n_cmp++; if (wr_data !== 32'h0) begin n_bad++; $display("FAIL mid_wr_data: got %h expected 0", wr_data); end
    n_cmp++; if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL mid_status: got cpu=%b done=%b err=%b expected 1 0 0", cpu_reset, done, error); end
    n_cmp++; if (words_loaded !== '0 || wr_addr !== '0 || wr_en !== 1'b0) begin n_bad++; $display("FAIL mid_counters: got wl=%0d addr=%0d en=%b expected 0 0 0", words_loaded, wr_addr, wr_en); end
    model(s);
    send_stream(s, 0, 0);
    n_cmp++; if (obs_data.size() != 2) begin n_bad++; $display("FAIL mid_nwrites: got %0d expected 2", obs_data.size()); end
    if (obs_data.size() == 2) begin
      n_cmp++; if (obs_data[1] !== 32'h20090003 || obs_addr[1] != 1) begin n_bad++; $display("FAIL mid_write1: got %0d:%h expected 1:20090003", obs_addr[1], obs_data[1]); end
    end
    n_cmp++; if (done !== 1'b1 || words_loaded !== 6'd2) begin n_bad++; $display("FAIL mid_final: got done=%b wl=%0d expected 1 2", done, words_loaded); end
  endtask

  // Random frames (noise, sizes incl. 0, 29..32, 33 and high-byte oversize,
  // occasional bad checksum, trailing junk, random gaps).
  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [7:0] s[$];
      logic [7:0] b, x;
      int n, r, gap;
      s.delete();
      repeat ($urandom_range(3, 0)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        s.push_back(b);
      end
      r = $urandom_range(9, 0);
      if (r < 6)       n = $urandom_range(6, 0);
      else if (r == 6) n = $urandom_range(MAX_WORDS, MAX_WORDS - 3);
      else if (r == 7) n = MAX_WORDS + 1;
      else if (r == 8) n = 256 * $urandom_range(255, 1);
      else             n = 0;
      s.push_back(8'hA5);
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      x = 8'(n >> 8) ^ 8'(n);
      if (n <= MAX_WORDS) begin
        for (int k = 0; k < 4 * n; k++) begin
          b = 8'($urandom);
          s.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        s.push_back(x);
      end
      repeat ($urandom_range(2, 0)) s.push_back(8'($urandom));
      gap = $urandom_range(2, 0);
      pulse_reset();
      model(s);
      send_stream(s, 0, gap);
      n_cmp++; if (acc_cyc.size() != exp_consumed) begin n_bad++; $display("FAIL rnd%0d_accepted: got %0d expected %0d", it, acc_cyc.size(), exp_consumed); end
      n_cmp++; if (obs_data.size() != exp_data.size()) begin n_bad++; $display("FAIL rnd%0d_nwrites: got %0d expected %0d", it, obs_data.size(), exp_data.size()); end
      for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
        n_cmp++;
        if (obs_data[k] !== exp_data[k] || obs_addr[k] != exp_addr[k] ||
            exp_wstream[k] >= acc_cyc.size() || obs_cyc[k] != acc_cyc[exp_wstream[k]]) begin
          n_bad++;
          $display("FAIL rnd%0d_write%0d: got %0d:%h cyc %0d expected %0d:%h", it, k, obs_addr[k], obs_data[k], obs_cyc[k], exp_addr[k], exp_data[k]);
        end
      end
      n_cmp++; if (done !== exp_done || error !== exp_err || cpu_reset !== !exp_done) begin n_bad++; $display("FAIL rnd%0d_status: got d=%b e=%b c=%b expected d=%b e=%b", it, done, error, cpu_reset, exp_done, exp_err); end
      n_cmp++; if (int'(words_loaded) != exp_loaded) begin n_bad++; $display("FAIL rnd%0d_words_loaded: got %0d expected %0d", it, words_loaded, exp_loaded); end
      n_cmp++; if (bus.in_ready !== !exp_term) begin n_bad++; $display("FAIL rnd%0d_in_ready: got %b expected %b", it, bus.in_ready, !exp_term); end
      n_cmp++; if (int'(wr_addr) != ((exp_loaded > 0) ? exp_loaded - 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_wr_addr: got %0d expected %0d", it, wr_addr, (exp_loaded > 0) ? exp_loaded - 1 : 0); end
      if (exp_term) begin
        n_cmp++; if (term_done !== exp_done || term_err !== exp_err) begin n_bad++; $display("FAIL rnd%0d_term_edge: got d=%b e=%b expected d=%b e=%b", it, term_done, term_err, exp_done, exp_err); end
      end
    end
  endtask

  task automatic test_max_words();
    logic [7:0] s[$];
    logic [7:0] b, x;
    s = {8'hA5, 8'h00, 8'(MAX_WORDS)};
    x = 8'(MAX_WORDS);
    for (int k = 0; k < 4 * MAX_WORDS; k++) begin
      b = 8'($urandom);
      s.push_back(b);
      x = x ^ b;
    end
    s.push_back(x);
    pulse_reset();
    model(s);
    send_stream(s, 0, 0);
    n_cmp++; if (obs_data.size() != MAX_WORDS) begin n_bad++; $display("FAIL max_nwrites: got %0d expected %0d", obs_data.size(), MAX_WORDS); end
    for (int k = 0; k < MAX_WORDS && k < obs_data.size(); k++) begin
      n_cmp++; if (obs_data[k] !== exp_data[k] || obs_addr[k] != k) begin n_bad++; $display("FAIL max_write%0d: got %0d:%h expected %0d:%h", k, obs_addr[k], obs_data[k], k, exp_data[k]); end
    end
    n_cmp++; if (done !== 1'b1 || int'(words_loaded) != MAX_WORDS) begin n_bad++; $display("FAIL max_final: got done=%b wl=%0d expected 1 %0d", done, words_loaded, MAX_WORDS); end
    n_cmp++; if (int'(wr_addr) != MAX_WORDS - 1) begin n_bad++; $display("FAIL max_wr_addr: got %0d expected %0d", wr_addr, MAX_WORDS - 1); end
  endtask

  initial begin
    reset = 1;
    bus.in_valid = 0;
    bus.in_data  = 8'h00;
    clear_obs();
    @(negedge clk);
    test_reset();
    test_normal();
    test_noise_gaps();
    test_bad_checksum();
    test_oversize();
    test_empty();
    test_reset_mid();
    test_max_words();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
    $fatal(1);
  end

  // done and error must never be high together
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1 && error === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_error_exclusive: got done=1 error=1 expected not both");
    end
  end
endmodule
